// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser_if
// Description : Handshake bundle between the vending FSM / hoppers and the
//               change dispenser. The master side is the environment that
//               issues vend strobes and acknowledges hopper requests. The
//               slave side is the dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
interface change_dispenser_if #(
  parameter int CHARGE_WIDTH = 2
);
  // Sale strobe and change code from the vending FSM
  logic                    vend;
  logic [CHARGE_WIDTH-1:0] charge;
  // Hopper acknowledges and error clear
  logic                    item_ack;
  logic                    coin_ack;
  logic                    err_clr;
  // Requests and status from the dispenser
  logic                    item_req;
  logic                    coin_req;
  logic                    coin_sel;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output vend, charge, item_ack, coin_ack, err_clr,
    input  item_req, coin_req, coin_sel, busy, done, err
  );

  modport slave (
    input  vend, charge, item_ack, coin_ack, err_clr,
    output item_req, coin_req, coin_sel, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Payout stage after the vending FSM. On a vend strobe it
//               requests one item, then pays the change as 10/20-unit coins
//               over req/ack handshakes. Each handshake has a timeout that
//               drops into a sticky error state. done pulses once per sale
//               that is paid out normally.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int CHARGE_WIDTH = 2,
  parameter int TIMEOUT      = 16,
  parameter bit USE_TWENTY   = 1'b1
) (
  input wire                 clk,
  input wire                 rst_n,
  change_dispenser_if.slave  bus
);

  // Wait counter only ever holds 0..TIMEOUT-2 before the timeout fires.
  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITEM = 3'd1,
    S_COIN = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rem_q, rem_d;         // outstanding change in 10-unit steps
  logic [WAIT_W-1:0] wait_q, wait_d;       // cycles spent waiting for an ack
  logic              err_flag_q, err_flag_d;

  logic              sel_twenty;           // coin type for the current rem
  logic [1:0]        rem_after_coin;       // rem once the current coin is paid

  // Coin choice depends only on what is still owed.
  always_comb begin
    sel_twenty     = USE_TWENTY && (rem_q >= 2'd2);
    rem_after_coin = rem_q - (sel_twenty ? 2'd2 : 2'd1);
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.item_req = (state_q == S_ITEM);
    bus.coin_req = (state_q == S_COIN);
    bus.coin_sel = (state_q == S_COIN) && sel_twenty;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.err      = (state_q == S_ERR);
  end

  // Next-state, change bookkeeping and handshake timeout.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    wait_d     = '0;                       // cleared on any entry to ITEM/COIN
    err_flag_d = err_flag_q;

    // err_clr always clears the flag. A reserved code or a timeout seen in
    // the same cycle sets it again below.
    if (bus.err_clr) begin
      err_flag_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.vend) begin
          state_d = S_ITEM;
          unique case (bus.charge)
            2'b01:   rem_d = 2'd1;
            2'b11:   rem_d = 2'd2;
            2'b10: begin
              rem_d      = 2'd0;
              err_flag_d = 1'b1;           // reserved code: sell, then error
            end
            default: rem_d = 2'd0;
          endcase
        end
      end

      S_ITEM: begin
        if (bus.item_ack) begin
          state_d = (rem_q == 2'd0) ? S_DONE : S_COIN;
        end else if (wait_q == WAIT_LAST) begin
          state_d    = S_ERR;
          err_flag_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_COIN: begin
        if (bus.coin_ack) begin
          rem_d   = rem_after_coin;
          state_d = (rem_after_coin == 2'd0) ? S_DONE : S_GAP;
        end else if (wait_q == WAIT_LAST) begin
          state_d    = S_ERR;
          err_flag_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // One idle cycle so coin_req visibly drops between coins.
      S_GAP: begin
        state_d = S_COIN;
      end

      S_DONE: begin
        state_d = err_flag_q ? S_ERR : S_IDLE;
      end

      S_ERR: begin
        if (bus.err_clr) begin
          state_d    = S_IDLE;
          err_flag_d = 1'b0;
          rem_d      = 2'd0;               // unpaid change is forfeited
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= 2'd0;
      wait_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser. Runs two instances
//               side by side, one paying 20-unit coins and one paying only
//               10-unit coins. A queue-based payout plan predicts the outputs
//               of each instance every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam int TIMEOUT = 5;

  // Payout plan entries. The head of the queue is the current activity.
  localparam int P_IDLE = 0;
  localparam int P_ITEM = 1;
  localparam int P_C10  = 2;
  localparam int P_C20  = 3;
  localparam int P_GAP  = 4;
  localparam int P_DONE = 5;
  localparam int P_ERR  = 6;

  typedef int plan_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vend_s;
  logic [1:0] charge_s;
  logic       err_clr_s;
  logic [1:0] item_ack_s, coin_ack_s;
  logic [1:0] auto_item, auto_coin;

  wire  [1:0] item_req_w, coin_req_w, coin_sel_w, busy_w, done_w, err_w;

  int    errors = 0;
  int    checks = 0;
  plan_t plan0, plan1;
  int    wt[2];
  bit    ef[2];
  int    ncoin[2], nsel[2], ndone[2], ngap[2];

  always #5 clk = ~clk;

  // Index 0 pays 20-unit coins where possible; index 1 pays only 10-unit coins.
  generate
    for (genvar i = 0; i < 2; i++) begin : g_dut
      change_dispenser_if #(.CHARGE_WIDTH(2)) bus ();
      assign bus.vend     = vend_s;
      assign bus.charge   = charge_s;
      assign bus.err_clr  = err_clr_s;
      assign bus.item_ack = item_ack_s[i];
      assign bus.coin_ack = coin_ack_s[i];
      assign item_req_w[i] = bus.item_req;
      assign coin_req_w[i] = bus.coin_req;
      assign coin_sel_w[i] = bus.coin_sel;
      assign busy_w[i]     = bus.busy;
      assign done_w[i]     = bus.done;
      assign err_w[i]      = bus.err;

      change_dispenser #(
        .CHARGE_WIDTH(2),
        .TIMEOUT     (TIMEOUT),
        .USE_TWENTY  ((i == 0) ? 1'b1 : 1'b0)
      ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
      );
    end
  endgenerate

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int head(input plan_t p);
    return (p.size() == 0) ? P_IDLE : p[0];
  endfunction

  // Advance one instance's payout plan by one clock edge using the inputs it sees.
  task automatic model_step(input bit use20, inout plan_t p, inout int w, inout bit e,
                            input bit iack, input bit cack);
    int h;
    int amt;
    h = head(p);
    case (h)
      P_IDLE: begin
        if (err_clr_s) e = 1'b0;
        if (vend_s) begin
          amt = (charge_s == 2'b01) ? 10 : (charge_s == 2'b11) ? 20 : 0;
          if (charge_s == 2'b10) e = 1'b1;
          p.push_back(P_ITEM);
          while (amt > 0) begin
            if (use20 && amt >= 20) begin
              p.push_back(P_C20);
              amt -= 20;
            end else begin
              p.push_back(P_C10);
              amt -= 10;
            end
            if (amt > 0) p.push_back(P_GAP);
          end
          p.push_back(P_DONE);
          w = 0;
        end
      end
      P_ITEM, P_C10, P_C20: begin
        if (err_clr_s) e = 1'b0;
        if ((h == P_ITEM) ? iack : cack) begin
          void'(p.pop_front());
          w = 0;
        end else if (w + 1 == TIMEOUT - 1) begin
          p.delete();
          p.push_back(P_ERR);
          e = 1'b1;
          w = 0;
        end else begin
          w++;
        end
      end
      P_GAP: begin
        if (err_clr_s) e = 1'b0;
        void'(p.pop_front());
      end
      P_DONE: begin
        void'(p.pop_front());
        if (e) p.push_back(P_ERR);
        if (err_clr_s) e = 1'b0;
      end
      default: begin
        if (err_clr_s) begin
          void'(p.pop_front());
          e = 1'b0;
        end
      end
    endcase
  endtask

  task automatic compare_dut(input int d, input plan_t p);
    int    h;
    string tag;
    h   = head(p);
    tag = (d == 0) ? "use20" : "use10";
    check({tag, ".item_req"}, int'(item_req_w[d]), int'(h == P_ITEM));
    check({tag, ".coin_req"}, int'(coin_req_w[d]), int'(h == P_C10 || h == P_C20));
    if (h == P_C10 || h == P_C20)
      check({tag, ".coin_sel"}, int'(coin_sel_w[d]), int'(h == P_C20));
    check({tag, ".busy"}, int'(busy_w[d]), int'(h != P_IDLE));
    check({tag, ".done"}, int'(done_w[d]), int'(h == P_DONE));
    check({tag, ".err"},  int'(err_w[d]),  int'(h == P_ERR));
  endtask

  // One clock: step models at the rising edge, compare and respond on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      plan0.delete();
      plan1.delete();
      wt[0] = 0; wt[1] = 0;
      ef[0] = 1'b0; ef[1] = 1'b0;
    end else begin
      model_step(1'b1, plan0, wt[0], ef[0], item_ack_s[0], coin_ack_s[0]);
      model_step(1'b0, plan1, wt[1], ef[1], item_ack_s[1], coin_ack_s[1]);
    end
    @(negedge clk);
    compare_dut(0, plan0);
    compare_dut(1, plan1);
    for (int d = 0; d < 2; d++) begin
      if (coin_req_w[d]) ncoin[d]++;
      if (coin_req_w[d] && coin_sel_w[d]) nsel[d]++;
      if (done_w[d]) ndone[d]++;
      if (busy_w[d] && !item_req_w[d] && !coin_req_w[d] && !done_w[d] && !err_w[d]) ngap[d]++;
      item_ack_s[d] = auto_item[d] & item_req_w[d];
      coin_ack_s[d] = auto_coin[d] & coin_req_w[d];
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      ncoin[d] = 0; nsel[d] = 0; ndone[d] = 0; ngap[d] = 0;
    end
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_w != 2'b00 && n < 40);
    check({name, ".settles_idle"}, int'(busy_w), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    vend_s     = 1'b0;
    charge_s   = 2'b00;
    err_clr_s  = 1'b0;
    item_ack_s = 2'b00;
    coin_ack_s = 2'b00;
    auto_item  = 2'b11;
    auto_coin  = 2'b11;
    wt[0] = 0; wt[1] = 0;
    ef[0] = 1'b0; ef[1] = 1'b0;
    clear_counts();

    // Reset values
    #12;
    check("rst.item_req", int'(item_req_w), 0);
    check("rst.coin_req", int'(coin_req_w), 0);
    check("rst.coin_sel", int'(coin_sel_w), 0);
    check("rst.busy",     int'(busy_w),     0);
    check("rst.done",     int'(done_w),     0);
    check("rst.err",      int'(err_w),      0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // No change: one item request, done, back to idle
    clear_counts();
    vend_s = 1'b1; charge_s = 2'b00;
    tick();
    vend_s = 1'b0;
    check("t1.item_req_next_cycle", int'(item_req_w), 3);
    tick();
    check("t1.done_pulse", int'(done_w), 3);
    tick();
    check("t1.busy_dropped", int'(busy_w), 0);
    check("t1.no_coins", ncoin[0] + ncoin[1], 0);

    // 20 change: one 20-coin vs two 10-coins with a gap
    clear_counts();
    vend_s = 1'b1; charge_s = 2'b11;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    run_idle("t2");
    check("t2.use20_coins", ncoin[0], 1);
    check("t2.use20_sel",   nsel[0],  1);
    check("t2.use20_gaps",  ngap[0],  0);
    check("t2.use10_coins", ncoin[1], 2);
    check("t2.use10_sel",   nsel[1],  0);
    check("t2.use10_gaps",  ngap[1],  1);
    check("t2.done_each",   ndone[0] + ndone[1], 2);

    // 10 change with coin_ack withheld: timeout into error
    clear_counts();
    auto_coin = 2'b00;
    vend_s = 1'b1; charge_s = 2'b01;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    n = 0;
    do begin
      tick();
      n++;
    end while (err_w != 2'b11 && n < 30);
    check("t3.err",             int'(err_w),  3);
    check("t3.busy",            int'(busy_w), 3);
    check("t3.use20_coin_hold", ncoin[0], TIMEOUT - 1);
    check("t3.use10_coin_hold", ncoin[1], TIMEOUT - 1);
    check("t3.no_done",         ndone[0] + ndone[1], 0);
    err_clr_s = 1'b1;
    tick();
    err_clr_s = 1'b0;
    check("t3.clr_busy", int'(busy_w), 0);
    check("t3.clr_err",  int'(err_w),  0);
    auto_coin = 2'b11;

    // Reserved code: item, done, then sticky error that blocks vend
    clear_counts();
    vend_s = 1'b1; charge_s = 2'b10;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    tick();
    check("t4.done_pulse", int'(done_w), 3);
    tick();
    check("t4.err_set", int'(err_w), 3);
    vend_s = 1'b1; charge_s = 2'b00;
    tick();
    vend_s = 1'b0;
    check("t4.vend_ignored", int'(item_req_w), 0);
    check("t4.still_err",    int'(err_w),      3);
    check("t4.no_coins",     ncoin[0] + ncoin[1], 0);
    err_clr_s = 1'b1;
    tick();
    err_clr_s = 1'b0;
    check("t4.cleared", int'(busy_w | err_w), 0);
    vend_s = 1'b1; charge_s = 2'b00;
    tick();
    vend_s = 1'b0;
    check("t4.next_vend_accepted", int'(item_req_w), 3);
    run_idle("t4");

    // Second vend during ITEM is dropped; stray coin_ack in IDLE is ignored
    clear_counts();
    auto_item = 2'b00;
    vend_s = 1'b1; charge_s = 2'b01;
    tick();
    charge_s = 2'b11;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    tick();
    check("t5.still_item", int'(item_req_w), 3);
    auto_item  = 2'b11;
    item_ack_s = 2'b11;
    run_idle("t5");
    check("t5.use20_one_coin", ncoin[0], 1);
    check("t5.use20_ten_only", nsel[0],  0);
    check("t5.use10_one_coin", ncoin[1], 1);
    coin_ack_s = 2'b11;
    tick();
    check("t5.stray_ack_busy", int'(busy_w),     0);
    check("t5.stray_ack_coin", int'(coin_req_w), 0);

    // Reset pulse during COIN, then a normal sale
    clear_counts();
    auto_coin = 2'b00;
    vend_s = 1'b1; charge_s = 2'b11;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    n = 0;
    while (coin_req_w != 2'b11 && n < 10) begin
      tick();
      n++;
    end
    check("t6.in_coin", int'(coin_req_w), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst_coin_req", int'(coin_req_w), 0);
    check("t6.rst_coin_sel", int'(coin_sel_w), 0);
    check("t6.rst_item_req", int'(item_req_w), 0);
    check("t6.rst_busy",     int'(busy_w),     0);
    check("t6.rst_done",     int'(done_w),     0);
    check("t6.rst_err",      int'(err_w),      0);
    tick();
    rst_n     = 1'b1;
    auto_coin = 2'b11;
    vend_s = 1'b1; charge_s = 2'b01;
    tick();
    vend_s = 1'b0; charge_s = 2'b00;
    run_idle("t6");
    check("t6.use20_done", ndone[0], 1);
    check("t6.use10_done", ndone[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
